// File: rtl/padring_pkg.sv
// Shared types and constants for the padring configuration sequencer.
package padring_pkg;

   localparam int PAD_CFG_WIDTH      = 8;
   localparam int PAD_TECH_CFG_WIDTH = 16;

   localparam int WE_BASE = 0;
   localparam int NO_BASE = 9;
   localparam int SO_BASE = 18;
   localparam int EA_BASE = 27;

   // Field order matches the request bus layout {tech_cfg, cfg, oen, ie}.
   typedef struct packed {
      logic [PAD_TECH_CFG_WIDTH-1:0] tech_cfg;
      logic [PAD_CFG_WIDTH-1:0]      cfg;
      logic                          oen;
      logic                          ie;
   } pad_cfg_t;

   localparam pad_cfg_t PAD_SAFE = '{tech_cfg: '0, cfg: '0, oen: 1'b1, ie: 1'b0};

   typedef enum logic {
      ST_IDLE,
      ST_APPLY
   } state_t;

endpackage

// File: rtl/padring_cfg_unpack.sv
// Maps the flat array of active pad settings onto the four per-side pad buses.
module padring_cfg_unpack
   import padring_pkg::*;
#(
   parameter int NGPIO          = 9,
   parameter int CFG_WIDTH      = 8,
   parameter int TECH_CFG_WIDTH = 16
) (
   input  pad_cfg_t                          active [4*NGPIO],
   output logic [NGPIO-1:0]                  we_ie,
   output logic [NGPIO-1:0]                  no_ie,
   output logic [NGPIO-1:0]                  so_ie,
   output logic [NGPIO-1:0]                  ea_ie,
   output logic [NGPIO-1:0]                  we_oen,
   output logic [NGPIO-1:0]                  no_oen,
   output logic [NGPIO-1:0]                  so_oen,
   output logic [NGPIO-1:0]                  ea_oen,
   output logic [NGPIO*CFG_WIDTH-1:0]        we_cfg,
   output logic [NGPIO*CFG_WIDTH-1:0]        no_cfg,
   output logic [NGPIO*CFG_WIDTH-1:0]        so_cfg,
   output logic [NGPIO*CFG_WIDTH-1:0]        ea_cfg,
   output logic [NGPIO*TECH_CFG_WIDTH-1:0]   we_tech_cfg,
   output logic [NGPIO*TECH_CFG_WIDTH-1:0]   no_tech_cfg,
   output logic [NGPIO*TECH_CFG_WIDTH-1:0]   so_tech_cfg,
   output logic [NGPIO*TECH_CFG_WIDTH-1:0]   ea_tech_cfg
);

   for (genvar gi = 0; gi < NGPIO; gi++) begin : g_pad
      assign we_ie[gi] = active[WE_BASE + gi].ie;
      assign no_ie[gi] = active[NO_BASE + gi].ie;
      assign so_ie[gi] = active[SO_BASE + gi].ie;
      assign ea_ie[gi] = active[EA_BASE + gi].ie;

      assign we_oen[gi] = active[WE_BASE + gi].oen;
      assign no_oen[gi] = active[NO_BASE + gi].oen;
      assign so_oen[gi] = active[SO_BASE + gi].oen;
      assign ea_oen[gi] = active[EA_BASE + gi].oen;

      assign we_cfg[gi*CFG_WIDTH +: CFG_WIDTH] = active[WE_BASE + gi].cfg;
      assign no_cfg[gi*CFG_WIDTH +: CFG_WIDTH] = active[NO_BASE + gi].cfg;
      assign so_cfg[gi*CFG_WIDTH +: CFG_WIDTH] = active[SO_BASE + gi].cfg;
      assign ea_cfg[gi*CFG_WIDTH +: CFG_WIDTH] = active[EA_BASE + gi].cfg;

      assign we_tech_cfg[gi*TECH_CFG_WIDTH +: TECH_CFG_WIDTH] = active[WE_BASE + gi].tech_cfg;
      assign no_tech_cfg[gi*TECH_CFG_WIDTH +: TECH_CFG_WIDTH] = active[NO_BASE + gi].tech_cfg;
      assign so_tech_cfg[gi*TECH_CFG_WIDTH +: TECH_CFG_WIDTH] = active[SO_BASE + gi].tech_cfg;
      assign ea_tech_cfg[gi*TECH_CFG_WIDTH +: TECH_CFG_WIDTH] = active[EA_BASE + gi].tech_cfg;
   end

endmodule

// File: rtl/padring_cfg_ctrl.sv
// Padring configuration sequencer: staged per-pad writes, committed one pad at a
// time with a fixed stagger so output drivers never all switch together.
module padring_cfg_ctrl
   import padring_pkg::*;
#(
   parameter int NGPIO          = 9,
   parameter int CFG_WIDTH      = PAD_CFG_WIDTH,
   parameter int TECH_CFG_WIDTH = PAD_TECH_CFG_WIDTH,
   parameter int STAGGER        = 4
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                req_valid,
   output logic                                req_ready,
   input  logic [5:0]                          req_addr,
   input  logic [2+CFG_WIDTH+TECH_CFG_WIDTH-1:0] req_data,
   input  logic                                commit,
   input  logic                                abort,
   output logic                                busy,
   output logic                                done,
   output logic                                err,
   output logic [NGPIO-1:0]                    we_ie,
   output logic [NGPIO-1:0]                    no_ie,
   output logic [NGPIO-1:0]                    so_ie,
   output logic [NGPIO-1:0]                    ea_ie,
   output logic [NGPIO-1:0]                    we_oen,
   output logic [NGPIO-1:0]                    no_oen,
   output logic [NGPIO-1:0]                    so_oen,
   output logic [NGPIO-1:0]                    ea_oen,
   output logic [NGPIO*CFG_WIDTH-1:0]          we_cfg,
   output logic [NGPIO*CFG_WIDTH-1:0]          no_cfg,
   output logic [NGPIO*CFG_WIDTH-1:0]          so_cfg,
   output logic [NGPIO*CFG_WIDTH-1:0]          ea_cfg,
   output logic [NGPIO*TECH_CFG_WIDTH-1:0]     we_tech_cfg,
   output logic [NGPIO*TECH_CFG_WIDTH-1:0]     no_tech_cfg,
   output logic [NGPIO*TECH_CFG_WIDTH-1:0]     so_tech_cfg,
   output logic [NGPIO*TECH_CFG_WIDTH-1:0]     ea_tech_cfg
);

   localparam int NPADS = 4 * NGPIO;
   localparam int CNT_W = (STAGGER > 1) ? $clog2(STAGGER) : 1;

   state_t             state_reg;
   logic [5:0]         idx_reg;
   logic [CNT_W-1:0]   cnt_reg;
   logic               done_reg;
   logic               err_reg;
   pad_cfg_t           staging_reg [NPADS];
   pad_cfg_t           active_reg  [NPADS];

   logic wr_accept;
   logic addr_ok;
   logic apply_now;

   assign wr_accept = req_valid && (state_reg == ST_IDLE);
   assign addr_ok   = (req_addr < 6'(NPADS));
   assign apply_now = (state_reg == ST_APPLY) && (cnt_reg == '0);

   assign req_ready = (state_reg == ST_IDLE);
   assign busy      = (state_reg == ST_APPLY);
   assign done      = done_reg;
   assign err       = err_reg;

   // Staging is untouched by abort so software can simply re-commit afterwards.
   for (genvar gi = 0; gi < NPADS; gi++) begin : g_bank
      always_ff @(posedge clk) begin
         if (rst) begin
            staging_reg[gi] <= PAD_SAFE;
         end else if (wr_accept && addr_ok && (req_addr == 6'(gi))) begin
            staging_reg[gi] <= pad_cfg_t'(req_data);
         end
      end

      always_ff @(posedge clk) begin
         if (rst || abort) begin
            active_reg[gi] <= PAD_SAFE;
         end else if (apply_now && (idx_reg == 6'(gi))) begin
            active_reg[gi] <= staging_reg[gi];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_IDLE;
         idx_reg   <= '0;
         cnt_reg   <= '0;
         done_reg  <= 1'b0;
         err_reg   <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         err_reg  <= wr_accept && !addr_ok;
         if (abort) begin
            state_reg <= ST_IDLE;
            idx_reg   <= '0;
            cnt_reg   <= '0;
         end else begin
            case (state_reg)
               ST_IDLE: begin
                  if (commit) begin
                     state_reg <= ST_APPLY;
                     idx_reg   <= '0;
                     cnt_reg   <= '0;
                  end
               end
               ST_APPLY: begin
                  if (cnt_reg == '0) begin
                     if (idx_reg == 6'(NPADS - 1)) begin
                        state_reg <= ST_IDLE;
                        done_reg  <= 1'b1;
                     end else begin
                        idx_reg <= idx_reg + 6'd1;
                        cnt_reg <= CNT_W'(STAGGER - 1);
                     end
                  end else begin
                     cnt_reg <= cnt_reg - 1'b1;
                  end
               end
               default: state_reg <= ST_IDLE;
            endcase
         end
      end
   end

   padring_cfg_unpack #(
      .NGPIO          (NGPIO),
      .CFG_WIDTH      (CFG_WIDTH),
      .TECH_CFG_WIDTH (TECH_CFG_WIDTH)
   ) u_unpack (
      .active      (active_reg),
      .we_ie       (we_ie),
      .no_ie       (no_ie),
      .so_ie       (so_ie),
      .ea_ie       (ea_ie),
      .we_oen      (we_oen),
      .no_oen      (no_oen),
      .so_oen      (so_oen),
      .ea_oen      (ea_oen),
      .we_cfg      (we_cfg),
      .no_cfg      (no_cfg),
      .so_cfg      (so_cfg),
      .ea_cfg      (ea_cfg),
      .we_tech_cfg (we_tech_cfg),
      .no_tech_cfg (no_tech_cfg),
      .so_tech_cfg (so_tech_cfg),
      .ea_tech_cfg (ea_tech_cfg)
   );

endmodule

// File: tb/tb_padring_cfg_ctrl.sv
// Directed bench: expected pad updates are queued at commit time and popped as
// pad outputs actually change, checking pad, edge and value.
module tb_padring_cfg_ctrl;
   import padring_pkg::*;

   localparam int NGPIO   = 9;
   localparam int NPADS   = 36;
   localparam int STAGGER = 4;
   localparam int LAST    = 1 + 35 * STAGGER;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [5:0]  req_addr = '0;
   logic [25:0] req_data = '0;
   logic        commit = 1'b0;
   logic        abort = 1'b0;
   logic        busy, done, err;
   logic [8:0]   we_ie, no_ie, so_ie, ea_ie, we_oen, no_oen, so_oen, ea_oen;
   logic [71:0]  we_cfg, no_cfg, so_cfg, ea_cfg;
   logic [143:0] we_tech_cfg, no_tech_cfg, so_tech_cfg, ea_tech_cfg;

   padring_cfg_ctrl #(.NGPIO(NGPIO), .CFG_WIDTH(8), .TECH_CFG_WIDTH(16), .STAGGER(STAGGER)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_data(req_data), .commit(commit), .abort(abort),
      .busy(busy), .done(done), .err(err),
      .we_ie(we_ie), .no_ie(no_ie), .so_ie(so_ie), .ea_ie(ea_ie),
      .we_oen(we_oen), .no_oen(no_oen), .so_oen(so_oen), .ea_oen(ea_oen),
      .we_cfg(we_cfg), .no_cfg(no_cfg), .so_cfg(so_cfg), .ea_cfg(ea_cfg),
      .we_tech_cfg(we_tech_cfg), .no_tech_cfg(no_tech_cfg),
      .so_tech_cfg(so_tech_cfg), .ea_tech_cfg(ea_tech_cfg)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   typedef struct {
      int       pad;
      int       cyc;
      pad_cfg_t val;
   } sb_t;

   sb_t      sbq[$];
   pad_cfg_t stage_m [NPADS];
   pad_cfg_t act_m   [NPADS];
   int tests = 0;
   int fails = 0;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   function automatic pad_cfg_t get_pad(input int p);
      pad_cfg_t r;
      int n;
      n = p % NGPIO;
      r = PAD_SAFE;
      case (p / NGPIO)
         0: r = '{tech_cfg: we_tech_cfg[n*16 +: 16], cfg: we_cfg[n*8 +: 8], oen: we_oen[n], ie: we_ie[n]};
         1: r = '{tech_cfg: no_tech_cfg[n*16 +: 16], cfg: no_cfg[n*8 +: 8], oen: no_oen[n], ie: no_ie[n]};
         2: r = '{tech_cfg: so_tech_cfg[n*16 +: 16], cfg: so_cfg[n*8 +: 8], oen: so_oen[n], ie: so_ie[n]};
         default: r = '{tech_cfg: ea_tech_cfg[n*16 +: 16], cfg: ea_cfg[n*8 +: 8], oen: ea_oen[n], ie: ea_ie[n]};
      endcase
      return r;
   endfunction

   task automatic check_all_pads(input string tag);
      for (int p = 0; p < NPADS; p++) chk(tag, 32'(get_pad(p)), 32'(act_m[p]));
   endtask

   task automatic wr(input logic [5:0] a, input pad_cfg_t d);
      chk("wr_ready", 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_addr  = a;
      req_data  = d;
      step();
      req_valid = 1'b0;
      chk("wr_err", 32'(err), 32'(a >= 6'd36));
      if (a < 6'd36) stage_m[a] = d;
      $display("[TB] write addr=%0d data=%h err=%0b", a, d, err);
   endtask

   task automatic do_commit(output int k);
      commit = 1'b1;
      step();
      commit = 1'b0;
      k = cyc;
      $display("[TB] commit at edge %0d", k);
   endtask

   // Scoreboard-driven apply run; abort_rel/commit_rel < 0 disables those events.
   task automatic run_apply(input int k, input int abort_rel, input int commit_rel);
      pad_cfg_t prev [NPADS];
      pad_cfg_t cur;
      sb_t      e;
      bit       fin;
      bit       exp_busy, exp_done;
      for (int p = 0; p < NPADS; p++) begin
         if (stage_m[p] != act_m[p]) sbq.push_back('{pad: p, cyc: k + 1 + p * STAGGER, val: stage_m[p]});
         prev[p] = get_pad(p);
      end
      fin = 0;
      while (!fin) begin
         abort  = (abort_rel >= 0) && (cyc == k + abort_rel);
         commit = (commit_rel >= 0) && (cyc == k + commit_rel);
         step();
         abort  = 1'b0;
         commit = 1'b0;
         if (abort_rel >= 0 && cyc == k + abort_rel + 1) begin
            for (int p = 0; p < NPADS; p++) act_m[p] = PAD_SAFE;
            sbq.delete();
            check_all_pads("abort_safe");
            chk("abort_busy", 32'(busy), 32'd0);
            for (int i = 0; i < 5; i++) begin
               chk("abort_no_done", 32'(done), 32'd0);
               step();
            end
            $display("[TB] abort at edge %0d, pads safe", k + abort_rel + 1);
            fin = 1;
         end else begin
            for (int p = 0; p < NPADS; p++) begin
               cur = get_pad(p);
               if (cur != prev[p]) begin
                  if (sbq.size() == 0) begin
                     chk("unexp_chg", 32'(p), 32'hFFFF_FFFF);
                  end else begin
                     e = sbq.pop_front();
                     chk("pad_idx", 32'(p), 32'(e.pad));
                     chk("pad_cyc", 32'(cyc), 32'(e.cyc));
                     chk("pad_val", 32'(cur), 32'(e.val));
                     act_m[e.pad] = e.val;
                     $display("[TB] pad %0d updated at edge %0d value=%h", p, cyc, cur);
                  end
                  prev[p] = cur;
               end
            end
            exp_done = (cyc == k + LAST);
            exp_busy = (cyc < k + LAST);
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("done", 32'(done), 32'(exp_done));
            chk("ready", 32'(req_ready), 32'(!exp_busy));
            if (exp_done) begin
               chk("sb_empty", 32'(sbq.size()), 32'd0);
               $display("[TB] done at edge %0d", cyc);
               fin = 1;
            end
         end
      end
   endtask

   initial begin
      int k;
      pad_cfg_t d;
      for (int p = 0; p < NPADS; p++) begin
         stage_m[p] = PAD_SAFE;
         act_m[p]   = PAD_SAFE;
      end

      // Reset state
      repeat (3) step();
      rst = 1'b0;
      repeat (10) step();
      check_all_pads("rst_pad");
      chk("rst_we_oen", 32'(we_oen), 32'h1FF);
      chk("rst_ea_oen", 32'(ea_oen), 32'h1FF);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_ready", 32'(req_ready), 32'd1);
      $display("[TB] reset checked");

      // Single-pad commit
      wr(6'd27, '{tech_cfg: 16'hABCD, cfg: 8'h5A, oen: 1'b0, ie: 1'b1});
      chk("no_early_apply", 32'(get_pad(27)), 32'(PAD_SAFE));
      do_commit(k);
      run_apply(k, -1, -1);
      chk("ea_cfg0", 32'(ea_cfg[7:0]), 32'h5A);
      chk("ea_tech0", 32'(ea_tech_cfg[15:0]), 32'hABCD);

      // Stagger ordering across all 36 pads
      for (int p = 0; p < NPADS; p++) wr(6'(p), '{tech_cfg: 16'(p * 257 + 1), cfg: 8'(p + 1), oen: 1'b0, ie: 1'b1});
      do_commit(k);
      run_apply(k, -1, -1);

      // Abort mid-apply, then re-commit
      for (int p = 0; p < NPADS; p++) wr(6'(p), '{tech_cfg: 16'(p * 3 + 7), cfg: 8'(p) ^ 8'hA5, oen: 1'b1, ie: 1'b1});
      do_commit(k);
      run_apply(k, 50, -1);
      do_commit(k);
      run_apply(k, -1, -1);

      // Bad address: err pulse, no state change
      wr(6'd40, '{tech_cfg: 16'hFFFF, cfg: 8'hFF, oen: 1'b0, ie: 1'b1});
      step();
      chk("err_pulse_end", 32'(err), 32'd0);
      check_all_pads("bad_addr_nochg");

      // Write held during APPLY is accepted once the sequencer returns to idle
      wr(6'd3, '{tech_cfg: 16'h1234, cfg: 8'h33, oen: 1'b0, ie: 1'b0});
      do_commit(k);
      d = '{tech_cfg: 16'h0F0F, cfg: 8'hC3, oen: 1'b0, ie: 1'b1};
      req_valid = 1'b1;
      req_addr  = 6'd5;
      req_data  = d;
      run_apply(k, -1, -1);
      step();
      req_valid = 1'b0;
      stage_m[5] = d;
      chk("held_wr_err", 32'(err), 32'd0);
      chk("held_wr_not_live", 32'(get_pad(5)), 32'(act_m[5]));
      $display("[TB] held write accepted at edge %0d", cyc);
      do_commit(k);
      run_apply(k, -1, -1);

      // Commit during APPLY is ignored
      wr(6'd20, '{tech_cfg: 16'h5555, cfg: 8'h11, oen: 1'b1, ie: 1'b0});
      do_commit(k);
      run_apply(k, -1, 20);
      for (int i = 0; i < 8; i++) begin
         step();
         chk("no_second_busy", 32'(busy), 32'd0);
         chk("no_second_done", 32'(done), 32'd0);
      end

      // Write and commit in the same idle cycle
      d = '{tech_cfg: 16'hBEEF, cfg: 8'h7E, oen: 1'b0, ie: 1'b1};
      req_valid = 1'b1;
      req_addr  = 6'd10;
      req_data  = d;
      commit    = 1'b1;
      step();
      req_valid = 1'b0;
      commit    = 1'b0;
      stage_m[10] = d;
      k = cyc;
      $display("[TB] write+commit at edge %0d", k);
      run_apply(k, -1, -1);
      chk("wc_pad10", 32'(get_pad(10)), 32'(d));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
